// File: rtl/dzcpu_uop_pkg.sv
// Shared micro-op field layout, ctrl encodings and sequencer state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dzcpu_uop_pkg;

  // Micro-op word: {ctrl[3:0], op[4:0], operand[3:0]}
  localparam int UOP_W    = 13;
  localparam int CTRL_W   = 4;
  localparam int OP_W     = 5;
  localparam int OPND_W   = 4;
  localparam int CTRL_MSB = 12;
  localparam int CTRL_LSB = 9;
  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 4;
  localparam int OPND_MSB = 3;
  localparam int OPND_LSB = 0;

  // Control-field encodings shared by the ucode macros, the ROM and the decoder
  typedef enum logic [CTRL_W-1:0] {
    CTRL_OP           = 4'd0,
    CTRL_INC          = 4'd1,
    CTRL_EOF          = 4'd2,
    CTRL_INC_EOF      = 4'd3,
    CTRL_EOF_FU       = 4'd4,
    CTRL_INC_EOF_FU   = 4'd5,
    CTRL_INC_EOF_Z    = 4'd6,
    CTRL_INC_EOF_NZ   = 4'd7,
    CTRL_UPDATE_FLAGS = 4'd8,
    CTRL_JCB          = 4'd9,
    CTRL_NOP          = 4'd10
  } uop_ctrl_e;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    FETCH_WAIT = 3'd1,
    DISPATCH   = 3'd2,
    EXEC       = 3'd3,
    CB_WAIT    = 3'd4
  } seq_state_e;

  // Builds a micro-op word; the ucode macros expand to this
  function automatic logic [UOP_W-1:0] mk_uop(input uop_ctrl_e ctrl,
                                              input logic [OP_W-1:0] op,
                                              input logic [OPND_W-1:0] opnd);
    return {ctrl, op, opnd};
  endfunction

endpackage

// File: rtl/dzcpu_uop_ctrl_decode.sv
// Decodes a micro-op ctrl field plus the Z flag into sequencer actions.
// Latency: purely combinational.
// Backpressure: none; the caller gates the results with its own stall.
module dzcpu_uop_ctrl_decode
  import dzcpu_uop_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              flag_z,
  output logic              inc,
  output logic              eof,
  output logic              fu,
  output logic              jcb,
  output logic              suppress
);

  // Map each ctrl code to its strobe set; unknown codes behave as nop
  always_comb begin
    inc      = 1'b0;
    eof      = 1'b0;
    fu       = 1'b0;
    jcb      = 1'b0;
    suppress = 1'b0;
    case (ctrl)
      CTRL_INC:          inc = 1'b1;
      CTRL_EOF:          eof = 1'b1;
      CTRL_INC_EOF:      begin inc = 1'b1; eof = 1'b1; end
      CTRL_EOF_FU:       begin fu = 1'b1; eof = 1'b1; end
      CTRL_INC_EOF_FU:   begin inc = 1'b1; fu = 1'b1; eof = 1'b1; end
      CTRL_UPDATE_FLAGS: fu = 1'b1;
      CTRL_JCB:          begin inc = 1'b1; jcb = 1'b1; end
      // Conditional end: when taken the op field must not execute
      CTRL_INC_EOF_Z: begin
        inc      = 1'b1;
        eof      = flag_z;
        suppress = flag_z;
      end
      CTRL_INC_EOF_NZ: begin
        inc      = 1'b1;
        eof      = ~flag_z;
        suppress = ~flag_z;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// Fetches opcodes, dispatches through the flow LUTs and steps the micro-op ROM.
// Latency: MEM_LATENCY fetch cycles + 1 dispatch cycle before the first micro-op.
// Backpressure: iStall freezes all state and forces every strobe low.
module dzcpu_uop_sequencer
  import dzcpu_uop_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_FLOW_LEN = 32
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStall,
  input  logic [7:0]       iMemData,
  input  logic             iFlagZ,
  output logic [7:0]       oMop,
  input  logic [7:0]       iFlowIdx,
  input  logic [7:0]       iCbFlowIdx,
  output logic [7:0]       oUopAddr,
  input  logic [UOP_W-1:0] iUop,
  output logic             oUopValid,
  output logic             oIncPc,
  output logic             oUpdateFlags,
  output logic             oInstrDone,
  output logic             oUopError
);

  // Latency counter must also hold MEM_LATENCY: CB_WAIT spends one extra
  // cycle after latching so the CB LUT sees the new oMop before loading.
  localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
  localparam int STEP_W = $clog2(MAX_FLOW_LEN + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LATENCY);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_FLOW_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_FLOW_LEN);

  seq_state_e        state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic [7:0]        mop_nxt, addr_nxt;
  logic              set_err;
  logic              dec_inc, dec_eof, dec_fu, dec_jcb, dec_suppress;
  logic              wd_hit, exec_ok;
  logic              uop_unused;

  // The op/operand fields go straight from the ROM to the datapath
  assign uop_unused = ^iUop[OP_MSB:OPND_LSB];

  dzcpu_uop_ctrl_decode u_dec (
    .ctrl     (iUop[CTRL_MSB:CTRL_LSB]),
    .flag_z   (iFlagZ),
    .inc      (dec_inc),
    .eof      (dec_eof),
    .fu       (dec_fu),
    .jcb      (dec_jcb),
    .suppress (dec_suppress)
  );

  // Watchdog fires on the last permitted micro-op unless it ends the flow anyway
  assign wd_hit  = (step_cnt >= STEP_LAST) && !dec_eof;
  assign exec_ok = (state == EXEC) && !iStall && !iReset;

  // State register and sequencer state; reset beats stall, stall beats everything else
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state     <= FETCH_WAIT;
      lat_cnt   <= '0;
      step_cnt  <= '0;
      oMop      <= '0;
      oUopAddr  <= '0;
      oUopError <= 1'b0;
    end else if (!iStall) begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      step_cnt <= step_nxt;
      oMop     <= mop_nxt;
      oUopAddr <= addr_nxt;
      if (set_err) oUopError <= 1'b1;
    end
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_nxt    = state;
    lat_nxt      = lat_cnt;
    step_nxt     = step_cnt;
    mop_nxt      = oMop;
    addr_nxt     = oUopAddr;
    set_err      = 1'b0;
    oUopValid    = 1'b0;
    oIncPc       = 1'b0;
    oUpdateFlags = 1'b0;
    oInstrDone   = 1'b0;
    case (state)
      RESET_HOLD: begin
        state_nxt = FETCH_WAIT;
        lat_nxt   = '0;
      end
      FETCH_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          mop_nxt   = iMemData;
          lat_nxt   = '0;
          state_nxt = DISPATCH;
        end else begin
          lat_nxt = lat_cnt + 1'b1;
        end
      end
      DISPATCH: begin
        addr_nxt  = iFlowIdx;
        step_nxt  = '0;
        state_nxt = EXEC;
      end
      EXEC: begin
        oUopValid    = exec_ok && !dec_suppress;
        oIncPc       = exec_ok && dec_inc;
        oUpdateFlags = exec_ok && dec_fu;
        oInstrDone   = exec_ok && (dec_eof || wd_hit);
        if (step_cnt != STEP_MAX) step_nxt = step_cnt + 1'b1;
        if (dec_eof || wd_hit) begin
          set_err   = wd_hit;
          lat_nxt   = '0;
          state_nxt = FETCH_WAIT;
        end else if (dec_jcb) begin
          lat_nxt   = '0;
          state_nxt = CB_WAIT;
        end else begin
          addr_nxt = oUopAddr + 8'd1;
        end
      end
      CB_WAIT: begin
        if (lat_cnt == LAT_LOAD) begin
          addr_nxt  = iCbFlowIdx;
          lat_nxt   = '0;
          state_nxt = EXEC;
        end else begin
          if (lat_cnt == LAT_LAST) mop_nxt = iMemData;
          lat_nxt = lat_cnt + 1'b1;
        end
      end
      default: state_nxt = FETCH_WAIT;
    endcase
  end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer with a small LUT/ROM model.
// Latency: MEM_LATENCY=1 so each fetch is FETCH_WAIT, DISPATCH, then EXEC.
// Backpressure: exercised by holding iStall mid-flow.
module tb_dzcpu_uop_sequencer;
  import dzcpu_uop_pkg::*;

  logic        clk;
  logic        iReset, iStall, iFlagZ;
  logic [7:0]  iMemData, oMop, iFlowIdx, iCbFlowIdx, oUopAddr;
  logic [12:0] iUop;
  logic        oUopValid, oIncPc, oUpdateFlags, oInstrDone, oUopError;
  logic [12:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  dzcpu_uop_sequencer #(.MEM_LATENCY(1), .MAX_FLOW_LEN(32)) dut (
    .iClock       (clk),
    .iReset       (iReset),
    .iStall       (iStall),
    .iMemData     (iMemData),
    .iFlagZ       (iFlagZ),
    .oMop         (oMop),
    .iFlowIdx     (iFlowIdx),
    .iCbFlowIdx   (iCbFlowIdx),
    .oUopAddr     (oUopAddr),
    .iUop         (iUop),
    .oUopValid    (oUopValid),
    .oIncPc       (oIncPc),
    .oUpdateFlags (oUpdateFlags),
    .oInstrDone   (oInstrDone),
    .oUopError    (oUopError)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main opcode LUT model
  function automatic logic [7:0] main_lut(input logic [7:0] op);
    case (op)
      8'h31:   return 8'd1;
      8'h20:   return 8'd17;
      8'hCB:   return 8'd13;
      8'hCD:   return 8'd49;
      8'hD3:   return 8'h90;
      default: return 8'd0;
    endcase
  endfunction

  // CB-prefix LUT model
  function automatic logic [7:0] cb_lut(input logic [7:0] op);
    case (op)
      8'h7C:   return 8'd16;
      default: return 8'd0;
    endcase
  endfunction

  assign iFlowIdx   = main_lut(oMop);
  assign iCbFlowIdx = cb_lut(oMop);
  assign iUop       = rom[oUopAddr];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic exp_cycle(input string tag, input logic [7:0] addr, input logic vld,
                           input logic inc, input logic fu, input logic done);
    chk_eq({tag, ".addr"}, oUopAddr, addr);
    chk_eq({tag, ".vld"},  oUopValid, vld);
    chk_eq({tag, ".inc"},  oIncPc, inc);
    chk_eq({tag, ".fu"},   oUpdateFlags, fu);
    chk_eq({tag, ".done"}, oInstrDone, done);
  endtask

  // Called at the negedge of a FETCH_WAIT cycle; returns at the first EXEC negedge
  task automatic fetch(input string tag, input logic [7:0] op);
    chk_eq({tag, ".fw_vld"}, oUopValid, 1'b0);
    chk_eq({tag, ".fw_done"}, oInstrDone, 1'b0);
    iMemData = op;
    tick();
    chk_eq({tag, ".mop"}, oMop, op);
    chk_eq({tag, ".dsp_vld"}, oUopValid, 1'b0);
    chk_eq({tag, ".dsp_done"}, oInstrDone, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk_uop(CTRL_NOP, 5'd0, 4'd0);
    rom[0]  = mk_uop(CTRL_INC_EOF, 5'd0, 4'd0);
    rom[1]  = mk_uop(CTRL_INC, 5'd1, 4'd1);
    rom[2]  = mk_uop(CTRL_INC, 5'd2, 4'd2);
    rom[3]  = mk_uop(CTRL_OP, 5'd3, 4'd3);
    rom[4]  = mk_uop(CTRL_INC_EOF, 5'd4, 4'd4);
    rom[13] = mk_uop(CTRL_OP, 5'd5, 4'd0);
    rom[14] = mk_uop(CTRL_OP, 5'd6, 4'd0);
    rom[15] = mk_uop(CTRL_JCB, 5'd0, 4'd0);
    rom[16] = mk_uop(CTRL_EOF_FU, 5'd7, 4'd1);
    rom[17] = mk_uop(CTRL_OP, 5'd8, 4'd0);
    rom[18] = mk_uop(CTRL_OP, 5'd9, 4'd0);
    rom[19] = mk_uop(CTRL_INC_EOF_Z, 5'd10, 4'd0);
    rom[20] = mk_uop(CTRL_INC, 5'd11, 4'd0);
    rom[21] = mk_uop(CTRL_OP, 5'd12, 4'd0);
    rom[22] = mk_uop(CTRL_EOF, 5'd13, 4'd0);
    rom[49] = mk_uop(CTRL_OP, 5'd14, 4'd0);
    rom[50] = mk_uop(CTRL_INC, 5'd15, 4'd0);
    rom[51] = mk_uop(CTRL_OP, 5'd16, 4'd0);
    rom[52] = mk_uop(CTRL_INC, 5'd17, 4'd0);
    rom[53] = mk_uop(CTRL_EOF, 5'd18, 4'd0);

    iReset = 1'b1; iStall = 1'b0; iFlagZ = 1'b0; iMemData = 8'h00;
    repeat (2) tick();
    exp_cycle("rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_eq("rst.mop", oMop, 8'h00);
    chk_eq("rst.err", oUopError, 1'b0);
    iReset = 1'b0;

    // LDSPnn
    fetch("ldsp", 8'h31);
    exp_cycle("ldsp1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    exp_cycle("ldsp2", 8'd2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    exp_cycle("ldsp3", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("ldsp4", 8'd4, 1'b1, 1'b1, 1'b0, 1'b1); tick();

    // JRNZn, Z=1: ends at 19 with the op suppressed
    iFlagZ = 1'b1;
    fetch("jrz", 8'h20);
    exp_cycle("jrz17", 8'd17, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("jrz18", 8'd18, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("jrz19", 8'd19, 1'b0, 1'b1, 1'b0, 1'b1); tick();

    // JRNZn, Z=0: continues through 22
    iFlagZ = 1'b0;
    fetch("jrnz", 8'h20);
    exp_cycle("jrnz17", 8'd17, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("jrnz18", 8'd18, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("jrnz19", 8'd19, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    exp_cycle("jrnz20", 8'd20, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    exp_cycle("jrnz21", 8'd21, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("jrnz22", 8'd22, 1'b1, 1'b0, 1'b0, 1'b1); tick();

    // CB prefix: 13,14,15(jcb), CB_WAIT latch, CB_WAIT load, 16
    fetch("cb", 8'hCB);
    exp_cycle("cb13", 8'd13, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("cb14", 8'd14, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("cb15", 8'd15, 1'b1, 1'b1, 1'b0, 1'b0);
    iMemData = 8'h7C;
    tick();
    exp_cycle("cbw0", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk_eq("cbw1.mop", oMop, 8'h7C);
    exp_cycle("cbw1", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("cb16", 8'd16, 1'b1, 1'b0, 1'b1, 1'b1); tick();

    // CALLnn with a 3-cycle stall at 51
    fetch("call", 8'hCD);
    exp_cycle("call49", 8'd49, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("call50", 8'd50, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    iStall = 1'b1;
    #1;
    exp_cycle("stall0", 8'd51, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      tick();
      exp_cycle($sformatf("stall%0d", k), 8'd51, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    iStall = 1'b0;
    #1;
    exp_cycle("call51", 8'd51, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    exp_cycle("call52", 8'd52, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    exp_cycle("call53", 8'd53, 1'b1, 1'b0, 1'b0, 1'b1); tick();

    // Watchdog: nop forever from 0x90, forced end on the 32nd micro-op
    fetch("wd", 8'hD3);
    for (int k = 0; k < 31; k++) begin
      chk_eq($sformatf("wd%0d.addr", k), oUopAddr, 8'h90 + k[7:0]);
      chk_eq($sformatf("wd%0d.done", k), oInstrDone, 1'b0);
      tick();
    end
    exp_cycle("wd31", 8'hAF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_eq("wd31.err", oUopError, 1'b0);
    tick();
    chk_eq("wd_fw.err", oUopError, 1'b1);
    fetch("gen", 8'h00);
    exp_cycle("gen0", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_eq("gen0.err", oUopError, 1'b1);
    tick();

    // Reset in the middle of JRNZn at addr 21
    fetch("rjr", 8'h20);
    exp_cycle("rjr17", 8'd17, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    tick(); tick(); tick();
    exp_cycle("rjr21", 8'd21, 1'b1, 1'b0, 1'b0, 1'b0);
    iReset = 1'b1;
    #1;
    exp_cycle("rjr_in", 8'd21, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    exp_cycle("rjr_post", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_eq("rjr_post.mop", oMop, 8'h00);
    chk_eq("rjr_post.err", oUopError, 1'b0);
    iReset = 1'b0;
    fetch("rjr_re", 8'h20);
    exp_cycle("rjr_re17", 8'd17, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dzcpu_uop_sequencer.md
Name: dzcpu_uop_sequencer

Overview:
- Micro-op sequencer for the dzcpu core, sitting between the memory data bus, the opcode→flow LUTs and the micro-op ROM.
- Latches each fetched opcode and drives it to the LUTs; takes back the flow start index and steps the ROM address one micro-op per enabled cycle.
- Decodes the control field of each micro-op (inc, eof, conditional eof, CB-prefix jump, flag update) and emits per-cycle strobes to the datapath.
- Starts the next opcode fetch when a flow ends.

Parameters:
- MEM_LATENCY, 1, cycles from PC address issue to valid opcode byte on iMemData (1..3).
- MAX_FLOW_LEN, 32, micro-op watchdog limit per instruction.

Ports:
- iClock in 1: single clock, all state on rising edge.
- iReset in 1: synchronous, active-high reset.
- iStall in 1: datapath/memory stall; freezes all sequencer state while high.
- iMemData in 8: memory read data (opcode / CB byte).
- iFlagZ in 1: current Z flag.
- oMop out 8: latched opcode to dzcpu_ucode_lut and dzcpu_ucode_cblut.
- iFlowIdx in 8: index from main LUT.
- iCbFlowIdx in 8: index from CB LUT.
- oUopAddr out 8: micro-op ROM address.
- iUop in 13: ROM micro-op {ctrl[3:0], op[4:0], operand[3:0]}.
- oUopValid out 1: iUop op/operand is to be executed this cycle.
- oIncPc out 1: PC increment strobe.
- oUpdateFlags out 1: flag writeback strobe.
- oInstrDone out 1: one-cycle pulse on the final micro-op of an instruction.
- oUopError out 1: sticky watchdog error.

Behaviour:
- States: RESET_HOLD, FETCH_WAIT, DISPATCH, EXEC, CB_WAIT.
- Reset value of every output is 0; state ← FETCH_WAIT; latency counter ← 0; step counter ← 0. Reset mid-flow aborts the flow immediately with no strobes.
- FETCH_WAIT:
  - Count MEM_LATENCY cycles, then latch iMemData into oMop and go to DISPATCH.
  - oUopValid=0 throughout.
- DISPATCH (1 cycle): oUopAddr ← iFlowIdx (index 0 = generic 1-byte flow), step ← 0, go to EXEC.
- EXEC:
  - oUopValid=1 each cycle. Decode ctrl and advance oUopAddr by 1 unless ending.
  - op/nop: no PC strobe.
  - inc: oIncPc=1.
  - eof: oInstrDone=1, go to FETCH_WAIT.
  - inc_eof: oIncPc=1 and oInstrDone=1.
  - eof_fu: oUpdateFlags=1 and oInstrDone=1.
  - inc_eof_fu: oIncPc, oUpdateFlags and oInstrDone all 1.
  - update_flags: oUpdateFlags=1; flow continues.
  - inc_eof_z: oIncPc=1 always. If iFlagZ=1, end (oInstrDone=1, oUopValid=0 so the op field is suppressed). Otherwise execute the uop and continue.
  - inc_eof_nz: same as inc_eof_z with the condition iFlagZ=0.
  - jcb: oIncPc=1, go to CB_WAIT.
- CB_WAIT: wait MEM_LATENCY cycles, latch iMemData into oMop, then oUopAddr ← iCbFlowIdx and go to EXEC. Step counter is not reset.
- Watchdog:
  - Step counter increments once per EXEC cycle and saturates.
  - Reaching MAX_FLOW_LEN without an eof forces an end: oInstrDone=1, oUopError←1 (sticky until reset), go to FETCH_WAIT.
- iStall=1:
  - Holds state, counters, oMop and oUopAddr.
  - All strobes (oUopValid, oIncPc, oUpdateFlags, oInstrDone) are forced to 0.
  - iStall has priority over every transition; iReset has priority over iStall.
- oUopAddr wraps 255→0 with no special handling.
- Strobes are combinational from the registered state and iUop, so the ROM is read in the same cycle.

Decomposition:
- Shared package dzcpu_uop_pkg holds:
  - the uop field widths and slice positions;
  - the ctrl encodings (op, inc, eof, inc_eof, eof_fu, inc_eof_fu, inc_eof_z, inc_eof_nz, update_flags, jcb, nop);
  - the state enum.
- The ucode macro definitions and the ROM are updated to use these encodings.
- One natural sub-module: dzcpu_uop_ctrl_decode, a combinational ctrl-field + Z → {inc, end, fu, jcb, suppress} decoder.

Test Plan:
- LDSPnn (0x31 → idx 1), MEM_LATENCY=1: oUopAddr 1,2,3,4 on consecutive EXEC cycles. oIncPc high at 1,2,4. oInstrDone pulses at 4, then FETCH_WAIT.
- JRNZn (0x20 → idx 17), iFlagZ=1: flow ends at addr 19 with oIncPc=1, oInstrDone=1, oUopValid=0. With iFlagZ=0: addrs 20,21,22 execute, done at 22.
- CB prefix: 0xCB → idx 13, then CB byte 0x7C → idx 16. Address sequence 13,14,15, CB_WAIT, 16. At 16, oUpdateFlags=1 and oInstrDone=1.
- Stall: assert iStall for 3 cycles at addr 51 of CALLnn. oUopAddr holds 51 and all strobes stay 0. Sequence resumes at 51→52.
- Reset at addr 21: all outputs 0 in the next cycle. Fetch restarts; no oInstrDone pulse for the aborted flow.
- Watchdog: ROM returns op/nop forever from idx 0x90. After 32 EXEC cycles, oInstrDone=1 and oUopError=1 (sticky), then FETCH_WAIT.
